mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single line-wide mem port between two cache requesters: port 0 = I-cache, port 1 = D-cache.
//  Takes level-held requests, grants one at a time, issues a one-cycle strobe to mem, waits for mem's
//  complete pulse, then returns the data or acknowledgement to the winner. Sits between the cache
//  refill/writeback logic and mem.
// PARAMETERS
//  ADDR_W   32                   request/mem address width
//  LINE_W   `CACHE_LINE_SIZE*8   line data width (bits)
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  rst            in   1       reset, asynchronous, active-low (0 = reset)
//  req_strobe     in   2       per-port request valid; held until that port's done pulse
//  req_read       in   2       per-port read request
//  req_write      in   2       per-port write request
//  req_addr       in   2*ADDR_W   per-port line address; port p at [p*ADDR_W +: ADDR_W]
//  req_wdata      in   2*LINE_W   per-port write line
//  rsp_rdata      out  LINE_W  read line; valid when rsp_rd_done[p]=1
//  rsp_rd_done    out  2       one-cycle read-complete pulse to port p
//  rsp_wr_done    out  2       one-cycle write-complete pulse to port p
//  mem_addr       out  ADDR_W  to mem addr
//  mem_strobe     out  1       to mem strobe
//  mem_read       out  1       to mem read_signal
//  mem_write      out  1       to mem write_signal
//  mem_wdata      out  LINE_W  to mem i_data
//  mem_rdata      in   LINE_W  from mem o_data
//  mem_rd_cmpl    in   1       from mem read_complete_signal
//  mem_wr_cmpl    in   1       from mem write_complete_signal
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; every output 0; grant and RR pointer cleared (last=1, port 0 favoured).
//  - States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//    IDLE: a port is pending when req_strobe[p] & (req_read[p]|req_write[p]). If any is pending,
//      arbitrate, latch gnt, addr, wdata and op into regs, go to ISSUE. Otherwise stay.
//    ISSUE (1 cycle): mem_strobe=1, mem_read/mem_write/mem_addr/mem_wdata from the latched regs. Go to WAIT.
//    WAIT: mem_strobe=0; mem_addr/mem_wdata/op stay held. Leave when mem_rd_cmpl (read op) or
//      mem_wr_cmpl (write op). On read, capture mem_rdata into rsp_rdata. Go to RESP.
//    RESP (1 cycle): rsp_rd_done[gnt] or rsp_wr_done[gnt] = 1. Update the RR pointer (last=gnt). Go to IDLE.
//  - Latency: pending in IDLE at cycle N -> strobe at N+1 -> done pulse one cycle after mem's complete pulse.
//    At most one mem transaction is in flight. mem_strobe is never high outside ISSUE.
//  - Read and write both set on one port: the write wins; the read is then served as a separate
//    later request if the requester still holds it.
//  - Complete pulse of the wrong type, or arriving in IDLE/ISSUE/RESP: ignored and dropped.
//  - rsp_rdata holds its last captured value until the next read capture. The requester must drop or
//    change req_strobe in the cycle after its done pulse, otherwise the request is re-arbitrated.
//  - Requester changing addr/wdata while its request is pending: no effect after the latch in IDLE.
//  - Reset during WAIT: returns to IDLE; the completion of the aborted mem transaction is dropped as a stray.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin. With both ports pending, the port != last wins; a single
//    pending port always wins.
//  MEM_ARB_RR_EN undefined: fixed priority, port 1 (D-cache) always beats port 0. The RR pointer
//    logic is removed.
// TESTING
//  1. Port0 read addr 0x40, memory line pattern -> strobe exactly 1 cycle, mem_addr=0x40, rsp_rd_done=01
//     once, rsp_rdata = line at 0x40.
//  2. Port1 write 0x80 with line 0xA5.., then port1 read 0x80 -> rsp_wr_done=10, then rsp_rd_done=10
//     with rdata 0xA5..
//  3. Both ports request reads in the same cycle, RR_EN defined, after reset -> port0 served first,
//     port1 second; with RR_EN undefined -> port1 first.
//  4. Both ports held continuously for 4 transactions, RR_EN defined -> grant sequence alternates 0,1,0,1.
//  5. Port0 sets read=write=1 at addr 0x100 -> mem_write=1, mem_read=0, rsp_wr_done=01.
//  6. rst pulled low during WAIT, released, then mem_rd_cmpl arrives -> all outputs 0, no done pulse,
//     state IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares the single line-wide memory port between two cache requesters
//   (port 0 = I-cache, port 1 = D-cache). Requests are level-held. One
//   request is granted at a time. The arbiter issues a one-cycle strobe to
//   memory and waits for the matching complete pulse. It then returns the
//   read line, or a write acknowledgement, to the winning port as a
//   one-cycle done pulse.
//
//   Configuration macro: MEM_ARB_RR_EN
//     defined   : round-robin between the two ports (last winner loses a tie)
//     undefined : fixed priority, port 1 always beats port 0
//
// Ports
//   clk, rst                   clock; asynchronous active-low reset
//   req_strobe/read/write[1:0] per-port request valid / read / write
//   req_addr  [2*ADDR_W]       per-port line address, port p at [p*ADDR_W +: ADDR_W]
//   req_wdata [2*LINE_W]       per-port write line,   port p at [p*LINE_W +: LINE_W]
//   rsp_rdata                  last captured read line
//   rsp_rd_done/wr_done[1:0]   one-cycle completion pulse per port
//   mem_addr/strobe/read/write/wdata   command to memory
//   mem_rdata, mem_rd_cmpl, mem_wr_cmpl response from memory
// ---------------------------------------------------------------------------
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 64
`endif

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = `CACHE_LINE_SIZE * 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_strobe,
  input  logic [1:0]          req_read,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*LINE_W-1:0] req_wdata,
  output logic [LINE_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_rd_done,
  output logic [1:0]          rsp_wr_done,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_strobe,
  output logic                mem_read,
  output logic                mem_write,
  output logic [LINE_W-1:0]   mem_wdata,
  input  logic [LINE_W-1:0]   mem_rdata,
  input  logic                mem_rd_cmpl,
  input  logic                mem_wr_cmpl
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;        // granted port
  logic                op_wr_q, op_wr_d;    // 1 = write, 0 = read
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          pending;
  logic                win;
  logic                cmpl_match;
  logic                in_resp;
  logic                cmd_active;

`ifdef MEM_ARB_RR_EN
  logic                last_q, last_d;      // port that was served last
`endif

  assign pending = req_strobe & (req_read | req_write);

  // Arbitration. A single pending port always wins. With both ports pending,
  // round-robin hands the grant to the port that was not served last.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (&pending) win = ~last_q;
    else          win = pending[1];
`else
    win = pending[1];
`endif
  end

  // Only a completion of the outstanding op type ends the wait. Strays of
  // the wrong type, or strays outside WAIT, are ignored.
  assign cmpl_match = op_wr_q ? mem_wr_cmpl : mem_rd_cmpl;

  // NOTE: every signal written here gets its default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|pending) begin
          gnt_d   = win;
          // The write wins when a port asks for both. Its read comes back
          // later as a fresh request if the requester still holds it.
          op_wr_d = req_write[win];
          addr_d  = win ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
          wdata_d = win ? req_wdata[2*LINE_W-1:LINE_W]  : req_wdata[LINE_W-1:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (cmpl_match) begin
          if (!op_wr_q) rdata_d = mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
`ifdef MEM_ARB_RR_EN
        last_d  = gnt_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  // NOTE: the wide data registers are reset as well, because they drive
  // outputs directly and every output must read 0 while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // The command stays visible through WAIT. Only the strobe is limited to ISSUE.
  assign cmd_active  = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign in_resp     = (state_q == S_RESP);

  assign mem_strobe  = (state_q == S_ISSUE);
  assign mem_read    = cmd_active & ~op_wr_q;
  assign mem_write   = cmd_active &  op_wr_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign rsp_rdata   = rdata_q;

  assign rsp_rd_done = {in_resp & ~op_wr_q &  gnt_q, in_resp & ~op_wr_q & ~gnt_q};
  assign rsp_wr_done = {in_resp &  op_wr_q &  gnt_q, in_resp &  op_wr_q & ~gnt_q};

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A transaction-level reference model
//   tracks requesters, the grant rule, a shadow of memory contents and the
//   expected done pulses. A behavioural memory answers each strobe after a
//   random latency and also injects stray completions.
//   Honours MEM_ARB_RR_EN in the same way as the design.
// ---------------------------------------------------------------------------
`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 64
`endif

module tb_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = `CACHE_LINE_SIZE * 8;
  typedef logic [LINE_W-1:0] line_t;
  typedef logic [ADDR_W-1:0] addr_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [1:0]          req_strobe, req_read, req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*LINE_W-1:0] req_wdata;
  line_t               rsp_rdata;
  logic [1:0]          rsp_rd_done, rsp_wr_done;
  addr_t               mem_addr;
  logic                mem_strobe, mem_read, mem_write;
  line_t               mem_wdata, mem_rdata;
  logic                mem_rd_cmpl, mem_wr_cmpl;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .req_strobe(req_strobe), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_rdata(rsp_rdata), .rsp_rd_done(rsp_rd_done), .rsp_wr_done(rsp_wr_done),
    .mem_addr(mem_addr), .mem_strobe(mem_strobe), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rd_cmpl(mem_rd_cmpl), .mem_wr_cmpl(mem_wr_cmpl)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // requesters
  bit    rq_on[2];
  bit    rq_rd[2];
  bit    rq_wr[2];
  addr_t rq_addr[2];
  line_t rq_wd[2];

  // reference model
  bit    idle_prev, in_txn, cmpl_prev;
  int    countdown;
  int    cur_port;
  bit    cur_wr;
  addr_t cur_addr;
  line_t cur_wd;
  int    m_last;
  line_t exp_rdata;
  line_t shadow[addr_t];
  int    done_log[$];

  // behavioural memory
  line_t mem_arr[addr_t];
  addr_t dut_addr;
  line_t dut_wd;

  // knobs
  bit hold_mode, gen_en, stray_en, force_stray;
  int lat_fix;

  task automatic chk(input string tag, input line_t obs, input line_t expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic line_t line_pat(input addr_t a);
    line_t l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = a ^ (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
    return l;
  endfunction

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic addr_t rand_addr();
    return addr_t'(($urandom_range(1, 4)) * 32'h40);
  endfunction

  function automatic line_t shadow_get(input addr_t a);
    return shadow.exists(a) ? shadow[a] : line_pat(a);
  endfunction

  function automatic line_t mem_get(input addr_t a);
    return mem_arr.exists(a) ? mem_arr[a] : line_pat(a);
  endfunction

  function automatic bit pend(input int p);
    return rq_on[p] && (rq_rd[p] || rq_wr[p]);
  endfunction

  // The grant rule at requester level: a lone requester wins; a tie goes to
  // the port not served last (RR) or always to the D-cache (fixed).
  function automatic int pick();
    if (pend(0) && pend(1)) begin
`ifdef MEM_ARB_RR_EN
      return (m_last == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    return pend(1) ? 1 : 0;
  endfunction

  function automatic int log_at(input int i);
    return (done_log.size() > i) ? done_log[i] : -1;
  endfunction

  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      req_strobe[p]                  = rq_on[p];
      req_read[p]                    = rq_rd[p];
      req_write[p]                   = rq_wr[p];
      req_addr[p*ADDR_W +: ADDR_W]   = rq_addr[p];
      req_wdata[p*LINE_W +: LINE_W]  = rq_wd[p];
    end
  endtask

  task automatic req(input int p, input bit rd, input bit wr, input addr_t a, input line_t wd);
    rq_on[p] = 1'b1; rq_rd[p] = rd; rq_wr[p] = wr; rq_addr[p] = a; rq_wd[p] = wd;
    drive();
  endtask

  // One clock cycle: check the DUT against the model, run the memory, update the requesters.
  task automatic step();
    logic [1:0] e_rd, e_wr;
    bit         e_strobe, resp_now, in_wait;
    @(negedge clk);
    resp_now = cmpl_prev;
    e_rd = 2'b00;
    e_wr = 2'b00;
    if (resp_now) begin
      if (cur_wr) e_wr[cur_port] = 1'b1;
      else begin
        e_rd[cur_port] = 1'b1;
        exp_rdata = shadow_get(cur_addr);
      end
    end
    chk("rsp_rd_done", line_t'(rsp_rd_done), line_t'(e_rd));
    chk("rsp_wr_done", line_t'(rsp_wr_done), line_t'(e_wr));
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    if (resp_now) begin
      done_log.push_back(cur_port);
      m_last = cur_port;
    end

    e_strobe = 1'b0;
    if (idle_prev && (pend(0) || pend(1))) begin
      e_strobe = 1'b1;
      cur_port = pick();
      cur_wr   = rq_wr[cur_port];
      cur_addr = rq_addr[cur_port];
      cur_wd   = rq_wd[cur_port];
      if (cur_wr) shadow[cur_addr] = cur_wd;
      in_txn   = 1'b1;
    end
    chk("mem_strobe", line_t'(mem_strobe), line_t'(e_strobe));
    if (e_strobe) begin
      chk("mem_addr", line_t'(mem_addr), line_t'(cur_addr));
      chk("mem_read", line_t'(mem_read), line_t'(!cur_wr));
      chk("mem_write", line_t'(mem_write), line_t'(cur_wr));
      if (cur_wr) chk("mem_wdata", mem_wdata, cur_wd);
      dut_addr  = mem_addr;
      dut_wd    = mem_wdata;
      countdown = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
    end

    in_wait     = in_txn && !e_strobe && !resp_now;
    mem_rd_cmpl = 1'b0;
    mem_wr_cmpl = 1'b0;
    cmpl_prev   = 1'b0;
    if (in_wait) begin
      countdown--;
      if (countdown == 0) begin
        cmpl_prev = 1'b1;
        if (cur_wr) begin
          mem_wr_cmpl       = 1'b1;
          mem_arr[dut_addr] = dut_wd;
        end else begin
          mem_rd_cmpl = 1'b1;
          mem_rdata   = mem_get(dut_addr);
        end
      end else if (stray_en && $urandom_range(0, 2) == 0) begin
        if (cur_wr) begin
          mem_rd_cmpl = 1'b1;
          mem_rdata   = rand_line();
        end else mem_wr_cmpl = 1'b1;
      end
    end else if (force_stray || (stray_en && $urandom_range(0, 7) == 0)) begin
      mem_rd_cmpl = 1'b1;
      mem_wr_cmpl = 1'($urandom_range(0, 1));
      mem_rdata   = rand_line();
      force_stray = 1'b0;
    end

    idle_prev = !in_txn;
    if (resp_now) begin
      in_txn = 1'b0;
      if (!hold_mode) rq_on[cur_port] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      if (gen_en && !rq_on[p] && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0, 1:    begin rq_rd[p] = 1'b1; rq_wr[p] = 1'b0; end
          2, 3:    begin rq_rd[p] = 1'b0; rq_wr[p] = 1'b1; end
          default: begin rq_rd[p] = 1'b1; rq_wr[p] = 1'b1; end
        endcase
        rq_on[p]   = 1'b1;
        rq_addr[p] = rand_addr();
        rq_wd[p]   = rand_line();
      end else if (gen_en && rq_on[p] && $urandom_range(0, 5) == 0) begin
        rq_addr[p] = rand_addr();
        rq_wd[p]   = rand_line();
      end
    end
    drive();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      rq_on[p] = 1'b0; rq_rd[p] = 1'b0; rq_wr[p] = 1'b0; rq_addr[p] = '0; rq_wd[p] = '0;
    end
    drive();
    mem_rd_cmpl = 1'b0;
    mem_wr_cmpl = 1'b0;
    mem_rdata   = '0;
    #1;
    chk("rst_mem_strobe", line_t'(mem_strobe), '0);
    chk("rst_mem_read", line_t'(mem_read), '0);
    chk("rst_mem_write", line_t'(mem_write), '0);
    chk("rst_mem_addr", line_t'(mem_addr), '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_rd_done", line_t'(rsp_rd_done), '0);
    chk("rst_wr_done", line_t'(rsp_wr_done), '0);
    idle_prev = 1'b1; in_txn = 1'b0; cmpl_prev = 1'b0; countdown = 0;
    m_last = 1; exp_rdata = '0; hold_mode = 1'b0; force_stray = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_idle(input int max, input string tag);
    int n = 0;
    while ((in_txn || pend(0) || pend(1)) && n < max) begin
      step();
      n++;
    end
    chk({tag, "_in_budget"}, line_t'(n < max), line_t'(1'b1));
  endtask

  task automatic run_log(input int cnt, input int max, input string tag);
    int n = 0;
    while (done_log.size() < cnt && n < max) begin
      step();
      n++;
    end
    chk({tag, "_in_budget"}, line_t'(n < max), line_t'(1'b1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    line_t a5_line;
    a5_line     = {(LINE_W / 8){8'hA5}};
    req_strobe  = '0; req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mem_rdata   = '0; mem_rd_cmpl = 1'b0; mem_wr_cmpl = 1'b0;
    gen_en      = 1'b0; stray_en = 1'b0; lat_fix = 0;
    do_reset();

    // port 0 reads a never-written line
    done_log.delete();
    req(0, 1'b1, 1'b0, 32'h40, '0);
    run_idle(50, "t1");
    chk("t1_port", line_t'(log_at(0)), line_t'(0));
    chk("t1_rdata", rsp_rdata, line_pat(32'h40));

    // port 1 writes a line, then reads it back
    done_log.delete();
    req(1, 1'b0, 1'b1, 32'h80, a5_line);
    run_idle(50, "t2w");
    req(1, 1'b1, 1'b0, 32'h80, '0);
    run_idle(50, "t2r");
    chk("t2_ports", line_t'(log_at(0) * 10 + log_at(1)), line_t'(11));
    chk("t2_rdata", rsp_rdata, a5_line);

    // read and write on the same port: the write is performed
    done_log.delete();
    req(0, 1'b1, 1'b1, 32'h100, rand_line());
    run_idle(50, "t5");
    chk("t5_count", line_t'(done_log.size()), line_t'(1));

    // simultaneous reads straight after reset
    do_reset();
    done_log.delete();
    req(0, 1'b1, 1'b0, 32'h40, '0);
    req(1, 1'b1, 1'b0, 32'h80, '0);
    run_idle(80, "t3");
`ifdef MEM_ARB_RR_EN
    chk("t3_order", line_t'(log_at(0) * 10 + log_at(1)), line_t'(1));
`else
    chk("t3_order", line_t'(log_at(0) * 10 + log_at(1)), line_t'(10));
`endif

    // both ports held across four transactions
    do_reset();
    done_log.delete();
    hold_mode = 1'b1;
    req(0, 1'b1, 1'b0, 32'hC0, '0);
    req(1, 1'b1, 1'b0, 32'h100, '0);
    run_log(4, 200, "t4");
    hold_mode = 1'b0;
    run_idle(100, "t4_drain");
`ifdef MEM_ARB_RR_EN
    chk("t4_seq", line_t'(log_at(0) * 1000 + log_at(1) * 100 + log_at(2) * 10 + log_at(3)), line_t'(101));
`else
    chk("t4_seq", line_t'(log_at(0) * 1000 + log_at(1) * 100 + log_at(2) * 10 + log_at(3)), line_t'(1111));
`endif

    // random traffic with stray completions and request changes while pending
    gen_en   = 1'b1;
    stray_en = 1'b1;
    repeat (1500) step();
    gen_en = 1'b0;
    run_idle(200, "rand");
    stray_en = 1'b0;

    // reset while waiting on memory, then a stray completion afterwards
    lat_fix = 20;
    req(0, 1'b1, 1'b0, 32'h40, '0);
    run_log(done_log.size(), 1, "t6_arm");
    for (int i = 0; i < 10 && !in_txn; i++) step();
    step();
    chk("t6_in_wait", line_t'(in_txn), line_t'(1'b1));
    do_reset();
    lat_fix = 0;
    done_log.delete();
    force_stray = 1'b1;
    repeat (6) step();
    chk("t6_no_done", line_t'(done_log.size()), line_t'(0));
    req(0, 1'b1, 1'b0, 32'h100, '0);
    run_idle(50, "t6_after");
    chk("t6_served", line_t'(log_at(0)), line_t'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
